harris_frame_ctrl: RTL and testbench
====================================

Name: harris_frame_ctrl

Overview:
- Frame-level sequencer for the Harris corner datapath.
- Accepts a raster pixel stream with a valid/ready handshake and drives the datapath clock enable and pixel bus.
- After the last pixel, flushes the window/pipeline latency.
- Maps each datapath output back to its (x,y) centre coordinate, masks borders, thresholds the score, and queues detected corners in a FIFO for downstream readout.

Parameters:
P_WIDTH, 640, active pixels per line
P_HEIGHT, 480, active lines per frame
P_PIPE, 1, datapath register stages between clk_en and a valid harris_feature
P_BORDER, 3, border pixels excluded on each edge (window + Sobel support)
P_FIFO_DEPTH, 16, corner FIFO entries (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
start  in  1  arm for next frame (pulse)
score_thresh  in  18  signed corner threshold
pix_valid  in  1  input pixel valid
pix_ready  out  1  controller accepts pixel
pix_rgb  in  24  {R,G,B} input pixel
dp_clk_en  out  1  clock enable to datapath
dp_rgb  out  24  pixel to datapath ({R,G,B})
harris_feature  in  18  signed score from datapath
corner_valid  out  1  FIFO head valid
corner_ready  in  1  downstream pop
corner_x  out  10  head x
corner_y  out  10  head y
corner_score  out  18  head score
corner_count  out  16  corners detected this frame (incl. dropped)
overflow  out  1  sticky: corner dropped on full FIFO this frame
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (reset==0 at clk edge) forces:
  - IDLE state.
  - All counters and FIFO pointers to 0.
  - All outputs 0: pix_ready, dp_clk_en, dp_rgb, corner_*, corner_count, overflow, busy, frame_done.
  - Reset mid-frame discards FIFO contents.
- Define D = 2*P_WIDTH + 2 + P_PIPE (window centre offset plus pipeline).
- States:
  - IDLE: pix_ready=0. On start → RUN; clears corner_count and overflow; FIFO is retained.
  - RUN: pix_ready=1. A beat is accepted when pix_valid&pix_ready. Each accepted beat gives dp_clk_en=1 and dp_rgb=pix_rgb in the same cycle (combinational pass-through, gated). Input counters ix (0..P_WIDTH-1) and iy advance on accept; ix wraps to 0 and increments iy. The accept of (P_WIDTH-1, P_HEIGHT-1) → FLUSH.
  - FLUSH: pix_ready=0. dp_clk_en=1 every cycle with dp_rgb=0, for exactly D cycles → DONE.
  - DONE: frame_done=1 for one cycle → IDLE. start in DONE is ignored.
- Enable counter n counts dp_clk_en cycles within the frame, from 0.
- Evaluation: on enable n ≥ D, harris_feature is evaluated for raster index n−D. Evaluation counters ex, ey start at (0,0) and advance one raster step per evaluated enable.
  - Over a frame, exactly P_WIDTH*P_HEIGHT evaluations occur and the last one lands on the final FLUSH cycle.
- Corner condition (all required):
  - P_BORDER ≤ ex ≤ P_WIDTH−1−P_BORDER
  - P_BORDER ≤ ey ≤ P_HEIGHT−1−P_BORDER
  - harris_feature > score_thresh (signed compare; equal is not a corner)
- On a corner:
  - corner_count += 1, saturating at 0xFFFF.
  - Push {ex,ey,harris_feature} if the FIFO is not full, else set overflow.
  - A simultaneous push and pop on a full FIFO succeeds; the pop frees the slot in the same cycle.
- FIFO:
  - Show-ahead: corner_valid = !empty; corner_x/y/score are valid while corner_valid is high.
  - Pop on corner_valid&corner_ready; popping when empty has no effect.
  - The FIFO drains independently of state, including in IDLE.
- The controller never stalls the pixel stream for FIFO space.
- dp_clk_en is never asserted in IDLE or DONE.

Test Plan:
- Small config W=8, H=6, P_PIPE=1, P_BORDER=1 (D=19):
  - Stimulus: start, then 48 pixels with continuous pix_valid.
  - Required: 48 RUN enables, 19 FLUSH enables, frame_done exactly 1 cycle after the last FLUSH enable, busy low afterwards.
- Bubbles: pix_valid toggling 1010…
  - Required: dp_clk_en only on accepted beats; evaluated coordinates identical to the continuous case.
- Thresholding: feature model returns 100 only at evaluation index 2*8+3 = (3,2), else 0; score_thresh=99.
  - Required: one FIFO entry (3,2,100) and corner_count=1.
  - With score_thresh=100: no entry.
- Border masking: feature=500 everywhere, thresh=0, P_BORDER=1.
  - Required: corner_count=24 (6×4), all entries with x in 1..6 and y in 1..4.
  - With P_FIFO_DEPTH=16 and corner_ready=0: 16 entries held, overflow=1.
- Reset mid-RUN (after 20 pixels) with reset=0 for one cycle:
  - Required: next cycle IDLE, pix_ready=0, corner_valid=0, corner_count=0.
  - A following start+frame behaves as in the first scenario.
- Simultaneous push/pop with the FIFO full:
  - Required: no overflow, occupancy unchanged, ordering preserved.

Source files
------------

// File: rtl/harris_frame_ctrl.sv
// Frame sequencer for the Harris corner datapath: feeds raster pixels, flushes
// the window latency, maps scores back to (x,y), masks borders and queues corners.
module harris_frame_ctrl #(
  parameter int unsigned P_WIDTH      = 640,
  parameter int unsigned P_HEIGHT     = 480,
  parameter int unsigned P_PIPE       = 1,
  parameter int unsigned P_BORDER     = 3,
  parameter int unsigned P_FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] score_thresh,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [23:0] pix_rgb,
  output logic        dp_clk_en,
  output logic [23:0] dp_rgb,
  input  logic [17:0] harris_feature,
  output logic        corner_valid,
  input  logic        corner_ready,
  output logic [9:0]  corner_x,
  output logic [9:0]  corner_y,
  output logic [17:0] corner_score,
  output logic [15:0] corner_count,
  output logic        overflow,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned D  = 2 * P_WIDTH + 2 + P_PIPE;
  localparam int unsigned FW = $clog2(D + 1);
  localparam int unsigned AW = $clog2(P_FIFO_DEPTH);

  localparam logic [9:0]    X_LAST     = 10'(P_WIDTH - 1);
  localparam logic [9:0]    Y_LAST     = 10'(P_HEIGHT - 1);
  localparam logic [9:0]    B_LO       = 10'(P_BORDER);
  localparam logic [9:0]    X_HI       = 10'(P_WIDTH - 1 - P_BORDER);
  localparam logic [9:0]    Y_HI       = 10'(P_HEIGHT - 1 - P_BORDER);
  localparam logic [FW-1:0] WARM_DONE  = FW'(D);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(D - 1);
  localparam logic [FW-1:0] FW_ONE     = FW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [9:0]    ix_q, ix_d, iy_q, iy_d;
  logic [9:0]    ex_q, ex_d, ey_q, ey_d;
  logic [FW-1:0] warm_q, warm_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [37:0]   mem_q [P_FIFO_DEPTH];

  logic          accept, en, eval, in_win, hit;
  logic          empty, full, push, pop;
  logic [37:0]   head;

  always_comb begin
    accept = (state_q == S_RUN) && pix_valid;
    en     = accept || (state_q == S_FLUSH);
    // warm_q saturates at D: from then on every enable evaluates one raster index
    eval   = en && (warm_q == WARM_DONE);
    in_win = (ex_q >= B_LO) && (ex_q <= X_HI) && (ey_q >= B_LO) && (ey_q <= Y_HI);
    hit    = eval && in_win && ($signed(harris_feature) > $signed(score_thresh));
    empty  = (wr_ptr_q == rd_ptr_q);
    full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop    = !empty && corner_ready;
    push   = hit && (!full || pop);
  end

  always_comb begin
    state_d  = state_q;
    ix_d     = ix_q;
    iy_d     = iy_q;
    ex_d     = ex_q;
    ey_d     = ey_q;
    warm_d   = warm_q;
    flush_d  = flush_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          ix_d    = '0;
          iy_d    = '0;
          ex_d    = '0;
          ey_d    = '0;
          warm_d  = '0;
          flush_d = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (accept) begin
          if (ix_q == X_LAST) begin
            ix_d = '0;
            iy_d = iy_q + 10'd1;
            if (iy_q == Y_LAST) state_d = S_FLUSH;
          end else begin
            ix_d = ix_q + 10'd1;
          end
        end
      end
      S_FLUSH: begin
        flush_d = flush_q + FW_ONE;
        if (flush_q == FLUSH_LAST) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    if (en && (warm_q != WARM_DONE)) warm_d = warm_q + FW_ONE;

    if (eval) begin
      if (ex_q == X_LAST) begin
        ex_d = '0;
        ey_d = ey_q + 10'd1;
      end else begin
        ex_d = ex_q + 10'd1;
      end
    end

    if (hit) begin
      if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
      if (!push) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      ix_q     <= '0;
      iy_q     <= '0;
      ex_q     <= '0;
      ey_q     <= '0;
      warm_q   <= '0;
      flush_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      ix_q     <= ix_d;
      iy_q     <= iy_d;
      ex_q     <= ex_d;
      ey_q     <= ey_d;
      warm_q   <= warm_d;
      flush_q  <= flush_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; contents are only visible through the pointer-derived valid
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {ex_q, ey_q, harris_feature};
  end

  always_comb begin
    head         = mem_q[rd_ptr_q[AW-1:0]];
    pix_ready    = (state_q == S_RUN);
    dp_clk_en    = en;
    dp_rgb       = accept ? pix_rgb : '0;
    corner_valid = !empty;
    corner_x     = corner_valid ? head[37:28] : '0;
    corner_y     = corner_valid ? head[27:18] : '0;
    corner_score = corner_valid ? head[17:0] : '0;
    corner_count = cnt_q;
    overflow     = ovf_q;
    busy         = (state_q != S_IDLE);
    frame_done   = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_harris_frame_ctrl.sv
// Self-checking bench for harris_frame_ctrl on an 8x6 frame: table of frame
// scenarios plus hand sequences for mid-frame reset and push/pop on a full FIFO.
module tb_harris_frame_ctrl;

  localparam int W = 8;
  localparam int H = 6;
  localparam int D = 2 * W + 2 + 1;

  logic               clk = 1'b0;
  logic               reset, start;
  logic signed [17:0] score_thresh;
  logic               pix_valid, pix_ready;
  logic [23:0]        pix_rgb;
  logic               dp_clk_en;
  logic [23:0]        dp_rgb;
  logic signed [17:0] harris_feature;
  logic               corner_valid, corner_ready;
  logic [9:0]         corner_x, corner_y;
  logic signed [17:0] corner_score;
  logic [15:0]        corner_count;
  logic               overflow, busy, frame_done;

  harris_frame_ctrl #(
    .P_WIDTH(W), .P_HEIGHT(H), .P_PIPE(1), .P_BORDER(1), .P_FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .score_thresh(score_thresh),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb),
    .dp_clk_en(dp_clk_en), .dp_rgb(dp_rgb), .harris_feature(harris_feature),
    .corner_valid(corner_valid), .corner_ready(corner_ready),
    .corner_x(corner_x), .corner_y(corner_y), .corner_score(corner_score),
    .corner_count(corner_count), .overflow(overflow), .busy(busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int s; } ent_t;
  typedef struct { int mode; int thresh; bit bub; bit live; int exp_cnt; bit exp_ovf; } vec_t;

  ent_t exp_q[$];
  vec_t vecs[8];

  int total = 0, bad = 0;
  int mode_v = 0;
  int en_cnt = 0;
  bit en_seen = 0, clr_seen = 0;
  int run_en = 0, flush_en = 0, viol = 0, pop_cnt = 0;
  bit prev_flush_en = 0, done_after_flush = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Feature model: score depends only on the raster index being evaluated
  function automatic int feat(input int m, input int idx);
    case (m)
      1:       return (idx == 2 * W + 3) ? 100 : 0;
      2:       return 500;
      3:       return ((idx * 37) % 101) - 50;
      4:       return -5;
      default: return 0;
    endcase
  endfunction

  assign harris_feature = (en_cnt >= D) ? 18'(feat(mode_v, en_cnt - D)) : 18'sd777;

  always @(posedge clk) begin
    if (clr_seen) en_cnt <= 0;
    else if (en_seen) en_cnt <= en_cnt + 1;
  end

  always @(negedge clk) begin
    bit          exp_en;
    logic [23:0] exp_rgb;
    ent_t        e;
    en_seen  = dp_clk_en;
    clr_seen = start;
    if (reset) begin
      if (start && !busy) begin
        run_en = 0;
        flush_en = 0;
        prev_flush_en = 0;
      end
      exp_en  = pix_ready ? pix_valid : (busy && !frame_done);
      exp_rgb = (pix_ready && pix_valid) ? pix_rgb : 24'd0;
      if (dp_clk_en !== exp_en) viol++;
      if (dp_rgb !== exp_rgb) viol++;
      if (frame_done) done_after_flush = prev_flush_en;
      if (dp_clk_en && pix_ready) run_en++;
      if (dp_clk_en && !pix_ready) flush_en++;
      prev_flush_en = dp_clk_en && !pix_ready;
      if (corner_valid && corner_ready) begin
        pop_cnt++;
        chk("pop_expected", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pop_x", corner_x, e.x);
          chk("pop_y", corner_y, e.y);
          chk("pop_score", corner_score, e.s);
        end
      end
    end
  end

  function automatic int gen_expected(input int m, input int th, input int limit);
    int cnt = 0;
    for (int idx = 0; idx < W * H; idx++) begin
      int x = idx % W;
      int y = idx / W;
      int f = feat(m, idx);
      if (x >= 1 && x <= W - 2 && y >= 1 && y <= H - 2 && f > th) begin
        cnt++;
        if (exp_q.size() < limit) exp_q.push_back('{x, y, f});
      end
    end
    return cnt;
  endfunction

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic drive_pixels(input bit bub, input int n);
    int sent = 0;
    bit tog = 1'b1;
    while (sent < n) begin
      pix_valid = bub ? tog : 1'b1;
      tog = !tog;
      pix_rgb = 24'($urandom);
      @(posedge clk);
      if (pix_valid) sent++;
      #1;
    end
    pix_valid = 1'b0;
    pix_rgb = '0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk); #1;
      if (frame_done) seen = 1;
    end
    chk("frame_done_seen", seen, 1);
    chk("run_enables", run_en, W * H);
    chk("flush_enables", flush_en, D);
    chk("done_after_last_flush", done_after_flush, 1);
    @(negedge clk); #1;
    chk("done_one_cycle", frame_done, 0);
    chk("busy_after_done", busy, 0);
    chk("dp_gating", viol, 0);
    viol = 0;
  endtask

  task automatic drain(input int exp_pops);
    @(posedge clk); #1 corner_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (!corner_valid) break;
    end
    corner_ready = 1'b0;
    chk("drained", corner_valid, 0);
    chk("pops", pop_cnt, exp_pops);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_frame(input vec_t v, output int cnt);
    int mc;
    mode_v = v.mode;
    score_thresh = 18'(v.thresh);
    corner_ready = v.live;
    mc = gen_expected(v.mode, v.thresh, v.live ? 1000000 : 16);
    cnt = (v.exp_cnt < 0) ? mc : v.exp_cnt;
    pop_cnt = 0;
    do_start();
    drive_pixels(v.bub, W * H);
    wait_done();
    corner_ready = 1'b0;
    chk("corner_count", corner_count, cnt);
    chk("overflow", overflow, v.exp_ovf);
  endtask

  initial begin
    int cnt;
    vecs[0] = '{1, 99, 0, 1, 1, 0};
    vecs[1] = '{1, 100, 0, 1, 0, 0};
    vecs[2] = '{1, 99, 1, 1, 1, 0};
    vecs[3] = '{2, 0, 0, 1, 24, 0};
    vecs[4] = '{4, -6, 1, 1, 24, 0};
    vecs[5] = '{4, -5, 0, 1, 0, 0};
    vecs[6] = '{3, 10, 1, 1, -1, 0};
    vecs[7] = '{2, 0, 0, 0, 24, 1};

    reset = 1'b0; start = 1'b0; pix_valid = 1'b0; pix_rgb = '0;
    corner_ready = 1'b0; score_thresh = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_dp_clk_en", dp_clk_en, 0);
    chk("rst_dp_rgb", dp_rgb, 0);
    chk("rst_corner_valid", corner_valid, 0);
    chk("rst_corner_x", corner_x, 0);
    chk("rst_corner_count", corner_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_frame(vecs[i], cnt);
      drain(vecs[i].live ? cnt : 16);
    end

    // Mid-frame reset with a retained corner sitting in the FIFO
    run_frame('{1, 99, 0, 0, 1, 0}, cnt);
    chk("valid_before_reset", corner_valid, 1);
    mode_v = 2;
    score_thresh = '0;
    do_start();
    drive_pixels(0, 20);
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b1;
    chk("rrst_pix_ready", pix_ready, 0);
    chk("rrst_corner_valid", corner_valid, 0);
    chk("rrst_corner_count", corner_count, 0);
    chk("rrst_busy", busy, 0);
    run_frame('{1, 99, 0, 1, 1, 0}, cnt);
    drain(cnt);

    // Fill the FIFO, then pop exactly on the cycle the next corner is pushed
    run_frame('{2, 0, 0, 0, 24, 1}, cnt);
    mode_v = 1;
    score_thresh = 18'sd99;
    corner_ready = 1'b0;
    exp_q.push_back('{3, 2, 100});
    pop_cnt = 0;
    do_start();
    fork
      drive_pixels(0, W * H);
      begin
        repeat (D + 2 * W + 3) @(posedge clk);
        #1 corner_ready = 1'b1;
        @(posedge clk);
        #1 corner_ready = 1'b0;
      end
    join
    wait_done();
    chk("pp_corner_count", corner_count, 1);
    chk("pp_overflow", overflow, 0);
    chk("pp_pops_in_frame", pop_cnt, 1);
    pop_cnt = 0;
    drain(16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
